// File: rtl/mips_16_pc_trace_monitor.sv
// Debug monitor for the mips_16 core: breakpoint match on the committed PC
// stream, halt/resume/single-step control, a PC trace FIFO and run counters.
module mips_16_pc_trace_monitor #(
  parameter int PC_WIDTH    = 8,
  parameter int NUM_BP      = 4,
  parameter int TRACE_DEPTH = 16,
  parameter int TRACE_WRAP  = 0,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PC_WIDTH-1:0]          pc_in,
  input  logic                         pc_valid,
  input  logic [NUM_BP-1:0]            bp_en,
  input  logic [NUM_BP*PC_WIDTH-1:0]   bp_addr,
  input  logic                         halt_req,
  input  logic                         resume,
  input  logic                         step,
  output logic                         halt,
  output logic                         hit_valid,
  output logic [2:0]                   hit_idx,
  input  logic                         trace_rd,
  output logic [PC_WIDTH-1:0]          trace_data,
  output logic                         trace_rd_valid,
  output logic                         trace_empty,
  output logic                         trace_full,
  output logic                         trace_ovf,
  output logic [CNT_WIDTH-1:0]         cycle_cnt,
  output logic [CNT_WIDTH-1:0]         instr_cnt
);

  localparam int AW = $clog2(TRACE_DEPTH);

  // state      | meaning
  // ST_RUN     | core free-running, breakpoints and halt_req armed
  // ST_HALTED  | core stalled, waiting for resume or step
  // ST_STEP    | core released for exactly one accepted PC
  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_STEP} state_t;

  state_t              state_q, state_d;
  logic                halt_q;
  logic                hit_valid_q;
  logic [2:0]          hit_idx_q;
  logic                skip_q;
  logic [PC_WIDTH-1:0] skip_pc_q;
  logic [PC_WIDTH-1:0] last_pc_q;

  logic                bp_hit_c;
  logic [2:0]          bp_idx_c;
  logic                hit_c;
  logic                accept_c;

  logic [PC_WIDTH-1:0] mem_q [TRACE_DEPTH];
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic [PC_WIDTH-1:0] trace_data_q;
  logic                trace_rd_valid_q;
  logic                trace_ovf_q;
  logic                empty_c, full_c, pop_c, write_c, drop_c, rd_adv_c;

  logic [CNT_WIDTH-1:0] cycle_q, instr_q;

  // Lowest-index enabled comparator matching the current PC; the re-presented
  // halting PC is masked once so resume does not immediately re-trigger.
  always_comb begin
    bp_hit_c = 1'b0;
    bp_idx_c = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc_in == bp_addr[i*PC_WIDTH +: PC_WIDTH])) begin
        bp_hit_c = 1'b1;
        bp_idx_c = 3'(i);
      end
    end
    accept_c = pc_valid && (state_q != ST_HALTED);
    hit_c    = (state_q == ST_RUN) && pc_valid && bp_hit_c &&
               !(skip_q && (pc_in == skip_pc_q));
  end

  // Next-state decode for the run/halt/step controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (hit_c || halt_req) state_d = ST_HALTED;
      ST_HALTED: begin
        if (step)        state_d = ST_STEP;
        else if (resume) state_d = ST_RUN;
      end
      ST_STEP:   if (pc_valid) state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Controller registers: state, registered halt, hit report and skip-once tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      halt_q      <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= 3'd0;
      skip_q      <= 1'b0;
      skip_pc_q   <= '0;
      last_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= (state_d == ST_HALTED);
      hit_valid_q <= hit_c;
      if (hit_c) hit_idx_q <= bp_idx_c;
      if (accept_c) begin
        skip_q    <= 1'b0;
        last_pc_q <= pc_in;
      end else if ((state_q == ST_HALTED) && (step || resume)) begin
        skip_q    <= 1'b1;
        skip_pc_q <= last_pc_q;
      end
    end
  end

  // FIFO bookkeeping; when full a simultaneous pop frees the slot for the push.
  always_comb begin
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_c    = trace_rd && !empty_c;
    drop_c   = accept_c && full_c && !pop_c;
    write_c  = accept_c && (!full_c || pop_c || (TRACE_WRAP != 0));
    rd_adv_c = pop_c || (drop_c && (TRACE_WRAP != 0));
  end

  // Trace pointers, read data register and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      trace_data_q     <= '0;
      trace_rd_valid_q <= 1'b0;
      trace_ovf_q      <= 1'b0;
    end else begin
      trace_rd_valid_q <= pop_c;
      if (pop_c)    trace_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      if (write_c)  wr_ptr_q     <= wr_ptr_q + 1'b1;
      if (rd_adv_c) rd_ptr_q     <= rd_ptr_q + 1'b1;
      if (drop_c)   trace_ovf_q  <= 1'b1;
    end
  end

  // Trace storage; in wrap mode the write lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (write_c) mem_q[wr_ptr_q[AW-1:0]] <= pc_in;
  end

  // Saturating run-cycle and accepted-instruction counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if ((state_q != ST_HALTED) && (cycle_q != '1)) cycle_q <= cycle_q + 1'b1;
      if (accept_c && (instr_q != '1))               instr_q <= instr_q + 1'b1;
    end
  end

  assign halt           = halt_q;
  assign hit_valid      = hit_valid_q;
  assign hit_idx        = hit_idx_q;
  assign trace_data     = trace_data_q;
  assign trace_rd_valid = trace_rd_valid_q;
  assign trace_empty    = empty_c;
  assign trace_full     = full_c;
  assign trace_ovf      = trace_ovf_q;
  assign cycle_cnt      = cycle_q;
  assign instr_cnt      = instr_q;

endmodule

// File: tb/tb_mips_16_pc_trace_monitor.sv
// Bench for mips_16_pc_trace_monitor: two instances (stop-when-full and wrap)
// share stimulus and are compared each cycle against a queue-based model.
module tb_mips_16_pc_trace_monitor;

  localparam int CW  = 6;
  localparam int MAXC = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pc_in = '0;
  logic        pc_valid = 1'b0;
  logic [3:0]  bp_en = '0;
  logic [31:0] bp_addr = '0;
  logic        halt_req = 1'b0, resume = 1'b0, step = 1'b0, trace_rd = 1'b0;

  logic          halt0, hv0, rv0, empty0, full0, ovf0;
  logic          halt1, hv1, rv1, empty1, full1, ovf1;
  logic [2:0]    hidx0, hidx1;
  logic [7:0]    data0, data1;
  logic [CW-1:0] cyc0, cyc1, ins0, ins1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_16_pc_trace_monitor #(.PC_WIDTH(8), .NUM_BP(4), .TRACE_DEPTH(16), .TRACE_WRAP(0), .CNT_WIDTH(CW)) u_dut0 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .bp_en(bp_en), .bp_addr(bp_addr),
    .halt_req(halt_req), .resume(resume), .step(step), .halt(halt0), .hit_valid(hv0), .hit_idx(hidx0),
    .trace_rd(trace_rd), .trace_data(data0), .trace_rd_valid(rv0), .trace_empty(empty0),
    .trace_full(full0), .trace_ovf(ovf0), .cycle_cnt(cyc0), .instr_cnt(ins0));

  mips_16_pc_trace_monitor #(.PC_WIDTH(8), .NUM_BP(4), .TRACE_DEPTH(16), .TRACE_WRAP(1), .CNT_WIDTH(CW)) u_dut1 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .bp_en(bp_en), .bp_addr(bp_addr),
    .halt_req(halt_req), .resume(resume), .step(step), .halt(halt1), .hit_valid(hv1), .hit_idx(hidx1),
    .trace_rd(trace_rd), .trace_data(data1), .trace_rd_valid(rv1), .trace_empty(empty1),
    .trace_full(full1), .trace_ovf(ovf1), .cycle_cnt(cyc1), .instr_cnt(ins1));

  // Reference model: 0 = running, 1 = halted, 2 = single-stepping.
  int         m_state;
  bit         m_halt, m_hv, m_rv, m_ovf0, m_ovf1, m_skip;
  int         m_hidx, m_cyc, m_ins;
  logic [7:0] m_skip_pc, m_last_pc, m_d0, m_d1;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_halt = 0; m_hv = 0; m_rv = 0; m_ovf0 = 0; m_ovf1 = 0; m_skip = 0;
    m_hidx = 0; m_cyc = 0; m_ins = 0; m_skip_pc = '0; m_last_pc = '0; m_d0 = '0; m_d1 = '0;
    q0.delete(); q1.delete();
  endtask

  task automatic model_step();
    bit acc, found;
    int idx, nst;
    acc = pc_valid && (m_state != 1);
    if (m_state != 1 && m_cyc < MAXC) m_cyc++;
    if (acc && m_ins < MAXC) m_ins++;
    found = 0; idx = 0;
    for (int i = 0; i < 4; i++)
      if (!found && bp_en[i] && bp_addr[i*8 +: 8] == pc_in) begin found = 1; idx = i; end
    m_hv = 0;
    nst  = m_state;
    case (m_state)
      0: begin
        if (acc && found && !(m_skip && pc_in == m_skip_pc)) begin
          m_hv = 1; m_hidx = idx; nst = 1;
        end else if (halt_req) nst = 1;
      end
      1: begin
        if (step || resume) begin
          nst = step ? 2 : 0;
          m_skip = 1; m_skip_pc = m_last_pc;
        end
      end
      default: if (acc) nst = 1;
    endcase
    if (acc) begin m_skip = 0; m_last_pc = pc_in; end
    m_rv = trace_rd && (q0.size() > 0);
    if (m_rv) begin m_d0 = q0.pop_front(); m_d1 = q1.pop_front(); end
    if (acc) begin
      if (q0.size() < 16) q0.push_back(pc_in); else m_ovf0 = 1;
      if (q1.size() >= 16) begin void'(q1.pop_front()); m_ovf1 = 1; end
      q1.push_back(pc_in);
    end
    m_state = nst;
    m_halt  = (nst == 1);
  endtask

  task automatic compare_all();
    check("halt0", halt0, m_halt);       check("halt1", halt1, m_halt);
    check("hit_valid0", hv0, m_hv);      check("hit_valid1", hv1, m_hv);
    check("hit_idx0", hidx0, m_hidx);    check("hit_idx1", hidx1, m_hidx);
    check("rd_valid0", rv0, m_rv);       check("rd_valid1", rv1, m_rv);
    check("data0", data0, m_d0);         check("data1", data1, m_d1);
    check("empty0", empty0, q0.size() == 0);  check("empty1", empty1, q1.size() == 0);
    check("full0", full0, q0.size() == 16);   check("full1", full1, q1.size() == 16);
    check("ovf0", ovf0, m_ovf0);         check("ovf1", ovf1, m_ovf1);
    check("cycle0", cyc0, m_cyc);        check("cycle1", cyc1, m_cyc);
    check("instr0", ins0, m_ins);        check("instr1", ins1, m_ins);
  endtask

  // Drive one cycle of inputs (called away from the rising edge), then check.
  task automatic cyc(input bit pv, input logic [7:0] pc, input bit hr, input bit rs, input bit st, input bit rd);
    pc_valid = pv; pc_in = pc; halt_req = hr; resume = rs; step = st; trace_rd = rd;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    pc_valid = 0; pc_in = '0; halt_req = 0; resume = 0; step = 0; trace_rd = 0;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 rst = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'd0, 0, 0, 0, 0);
  endtask

  initial begin
    #6;
    do_reset();
    check("rst_empty", empty0, 1'b1);
    check("rst_halt", halt0, 1'b0);

    // Breakpoint 0 at PC 6 while PCs 0..8 stream in.
    bp_en = 4'b0001; bp_addr = 32'h0000_0006;
    for (int p = 0; p <= 8; p++) begin
      cyc(1, 8'(p), 0, 0, 0, 0);
      if (p == 6) check("s1_hit_pulse", hv0, 1'b1);
    end
    check("s1_halt", halt0, 1'b1);
    check("s1_instr", ins0, 7);
    for (int i = 0; i <= 6; i++) begin
      cyc(0, 8'd0, 0, 0, 0, 1);
      check("s1_pop", data0, i);
    end
    check("s1_drained", empty0, 1'b1);

    // Two comparators at the same PC, then resume re-presents it.
    do_reset();
    bp_en = 4'b0101; bp_addr = 32'h000A_000A;
    cyc(1, 8'd10, 0, 0, 0, 0);
    check("s2_hit", hv0, 1'b1);
    check("s2_idx", hidx0, 0);
    idle(2);
    cyc(0, 8'd0, 0, 1, 0, 0);
    cyc(1, 8'd10, 0, 0, 0, 0);
    check("s2_no_rehit", hv0, 1'b0);
    check("s2_running", halt0, 1'b0);
    cyc(1, 8'd11, 0, 0, 0, 0);
    check("s2_run_on", halt0, 1'b0);

    // Single-step from a breakpoint at 6.
    do_reset();
    bp_en = 4'b0001; bp_addr = 32'h0000_0006;
    for (int p = 0; p <= 6; p++) cyc(1, 8'(p), 0, 0, 0, 0);
    idle(3);
    check("s3_frozen", cyc0, 7);
    for (int p = 7; p <= 9; p++) begin
      cyc(0, 8'd0, 0, 0, 1, 0);
      check("s3_step_release", halt0, 1'b0);
      idle(1);
      cyc(1, 8'(p), 0, 0, 0, 0);
      check("s3_step_halt", halt0, 1'b1);
      check("s3_step_nohit", hv0, 1'b0);
    end
    check("s3_instr", ins0, 10);

    // Overfill the trace with breakpoints off.
    do_reset();
    bp_en = 4'b0000;
    for (int p = 0; p < 20; p++) cyc(1, 8'(p), 0, 0, 0, 0);
    check("s4_full", full0, 1'b1);
    check("s4_ovf0", ovf0, 1'b1);
    check("s4_ovf1", ovf1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'd0, 0, 0, 0, 1);
      check("s4_pop_stop", data0, i);
      check("s4_pop_wrap", data1, i + 4);
    end
    check("s4_empty", empty0, 1'b1);

    // Pop on empty, then push+pop while full.
    cyc(0, 8'd0, 0, 0, 0, 1);
    check("s5_empty_pop", rv0, 1'b0);
    do_reset();
    for (int p = 0; p < 16; p++) cyc(1, 8'(p + 32), 0, 0, 0, 0);
    cyc(1, 8'd99, 0, 0, 0, 1);
    check("s5_full_kept", full0, 1'b1);
    check("s5_no_ovf", ovf0, 1'b0);
    check("s5_pop_data", data0, 32);

    // Asynchronous reset while halted with five entries.
    do_reset();
    bp_en = 4'b0001; bp_addr = 32'h0000_0004;
    for (int p = 0; p <= 4; p++) cyc(1, 8'(p), 0, 0, 0, 0);
    check("s6_halted", halt0, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("s6_halt_async", halt0, 1'b0);
    check("s6_empty", empty0, 1'b1);
    check("s6_cycle", cyc0, 0);
    check("s6_instr", ins0, 0);
    model_reset();
    #1 rst = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      if (($urandom % 32) == 0) begin
        bp_en   = 4'($urandom);
        bp_addr = {8'($urandom % 16), 8'($urandom % 16), 8'($urandom % 16), 8'($urandom % 16)};
      end
      cyc(($urandom % 4) != 0, 8'($urandom % 16), ($urandom % 16) == 0,
          ($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
